// File: rtl/sqrt2.sv
// Pipelined integer square root: Out = floor(sqrt(In * 2^14)), an 8.7 fixed-point root.
// One restoring digit-recurrence stage per result bit, 16 cycles from In to Out.
module sqrt2 (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] In,
  output logic [14:0] Out
);

  localparam int STAGES = 15;
  localparam int RAD_W  = 30;
  localparam int REM_W  = 18;
  localparam int ROOT_W = 15;

  logic [14:0] in_reg  = '0;
  logic [14:0] out_reg = '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_reg <= '0;
    end else begin
      in_reg <= In;
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [RAD_W-1:0]  rad_reg  = '0;
    logic [REM_W-1:0]  rem_reg  = '0;
    logic [ROOT_W-1:0] root_reg = '0;

    logic [RAD_W-1:0]  rad_in;
    logic [REM_W-1:0]  rem_in;
    logic [ROOT_W-1:0] root_in;

    if (gi == 0) begin : g_first
      // Radicand padded to an even width so bit pairs align from the top.
      assign rad_in  = {1'b0, in_reg, 14'b0};
      assign rem_in  = '0;
      assign root_in = '0;
    end else begin : g_next
      assign rad_in  = g_stage[gi-1].rad_reg;
      assign rem_in  = g_stage[gi-1].rem_reg;
      assign root_in = g_stage[gi-1].root_reg;
    end

    // The remainder never exceeds 2*root, so its top two bits are always zero here.
    logic [REM_W-1:0] rem_shift;
    logic [REM_W-1:0] trial;
    logic             fits;
    assign rem_shift = {rem_in[REM_W-3:0], rad_in[RAD_W-1:RAD_W-2]};
    assign trial     = {1'b0, root_in, 2'b01};
    assign fits      = (rem_shift >= trial);

    logic unused_stage;
    assign unused_stage = ^{rem_in[REM_W-1:REM_W-2], root_in[ROOT_W-1]};

    always_ff @(posedge clk) begin
      if (reset) begin
        rad_reg  <= '0;
        rem_reg  <= '0;
        root_reg <= '0;
      end else begin
        rad_reg  <= {rad_in[RAD_W-3:0], 2'b00};
        rem_reg  <= fits ? (rem_shift - trial) : rem_shift;
        root_reg <= {root_in[ROOT_W-2:0], fits};
      end
    end
  end

  // Dedicated output register after the last digit stage sets the 16-cycle latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg <= '0;
    end else begin
      out_reg <= g_stage[STAGES-1].root_reg;
    end
  end

  assign Out = out_reg;

  logic unused_tail;
  assign unused_tail = ^{g_stage[STAGES-1].rad_reg, g_stage[STAGES-1].rem_reg};

endmodule

// File: tb/tb_sqrt2.sv
// Bench for sqrt2: table vectors, reset corner sequences, random stream and a full sweep,
// all compared against a plain-arithmetic square-root model with 16-cycle alignment.
module tb_sqrt2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] In = '0;
  logic [14:0] Out;

  sqrt2 dut (
    .clk  (clk),
    .reset(reset),
    .In   (In),
    .Out  (Out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] in;
    logic [14:0] exp;
  } vec_t;

  vec_t        tab[6];
  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  logic [14:0] in_hist[$];
  bit          rst_hist[$];

  function automatic int ref_sqrt(input int v);
    longint n;
    longint r;
    n = longint'(v) * 64'd16384;
    r = longint'($floor($sqrt(real'(n))));
    while (r * r > n) r--;
    while ((r + 1) * (r + 1) <= n) r++;
    return int'(r);
  endfunction

  // Output after edge e comes from the input sampled at edge e-16, unless a reset
  // occurred at any edge from e-16 through e.
  function automatic logic [14:0] model_out(input int e);
    if (e < 16) return 15'd0;
    for (int j = e - 16; j <= e; j++)
      if (rst_hist[j]) return 15'd0;
    return 15'(ref_sqrt(int'(in_hist[e-16])));
  endfunction

  task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=0x%04h want=0x%04h", name, cyc, got, exp);
    end
  endtask

  task automatic step(input logic [14:0] v, input bit rst, output logic [14:0] got);
    In    = v;
    reset = rst;
    @(posedge clk);
    in_hist.push_back(v);
    rst_hist.push_back(rst);
    #1;
    got = Out;
    check("model", got, model_out(cyc));
    $display("cyc=%0d in=0x%04h rst=%0d out=0x%04h", cyc, v, rst, got);
    cyc++;
  endtask

  task automatic step_q(input logic [14:0] v, input bit rst);
    logic [14:0] got;
    In    = v;
    reset = rst;
    @(posedge clk);
    in_hist.push_back(v);
    rst_hist.push_back(rst);
    #1;
    got = Out;
    check("sweep", got, model_out(cyc));
    cyc++;
  endtask

  initial begin
    logic [14:0] got;

    tab[0] = '{in: 15'h0001, exp: 15'h0080};
    tab[1] = '{in: 15'h0002, exp: 15'h00B5};
    tab[2] = '{in: 15'h0004, exp: 15'h0100};
    tab[3] = '{in: 15'h0064, exp: 15'h0500};
    tab[4] = '{in: 15'h7FFF, exp: 15'h5A82};
    tab[5] = '{in: 15'h0009, exp: 15'h0180};

    for (int i = 0; i < 3; i++) step(15'd0, 1'b1, got);
    check("reset_out", got, 15'd0);

    // Zero held with a one-cycle reset pulse: output stays zero.
    for (int i = 0; i < 20; i++) begin
      step(15'd0, (i == 4), got);
      check("zero_hold", got, 15'd0);
    end

    // Streamed table operands on consecutive edges.
    for (int i = 0; i < 21; i++) begin
      step((i < 5) ? tab[i].in : 15'd0, 1'b0, got);
      if (i >= 16) check("table", got, tab[i-16].exp);
    end

    // Single operand surrounded by zeros.
    for (int i = 0; i < 20; i++) begin
      step((i == 0) ? tab[5].in : 15'd0, 1'b0, got);
      if (i == 16) check("single", got, tab[5].exp);
      else if (i >= 12) check("single_zero", got, 15'd0);
    end

    // Mid-stream reset: in-flight operands are discarded.
    for (int i = 0; i < 45; i++) begin
      step(15'($urandom_range(1, 32767)) & {15{i < 26}}, (i == 5), got);
      if (i >= 5 && i <= 21) check("flush", got, 15'd0);
    end

    // Random stream with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      step(15'($urandom), ($urandom_range(0, 99) == 0), got);
    end
    for (int i = 0; i < 17; i++) step(15'd0, 1'b0, got);

    // Exhaustive sweep, reset never asserted.
    for (int v = 0; v < 32768; v++) step_q(15'(v), 1'b0);
    for (int i = 0; i < 17; i++) step_q(15'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
